display_scan_mux: RTL and testbench

DISPLAY_SCAN_MUX -- requirements
Module: display_scan_mux

---
 rtl/display_pkg.sv | 17 +
 rtl/tick_div.sv | 29 ++
 rtl/display_scan_mux.sv | 85 ++++++++
 tb/tb_display_scan_mux.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the four-digit display scanner.
// Used by display_scan_mux and its divider sub-module.
package display_pkg;

    localparam int NDIG = 4;

    typedef logic [3:0] digit_t;
    typedef logic [1:0] sidx_t;

    localparam logic [3:0] AN_OFF = 4'b1111;

    // Active-low one-hot anode pattern for a scan position
    function automatic logic [3:0] an_sel(input sidx_t s);
        return ~(4'b0001 << s);
    endfunction

endpackage

// File: rtl/tick_div.sv
// Free-running divider: counts 0..DIV-1, wraps, and flags the terminal
// count as a single-cycle tick.
module tick_div #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int W = (DIV > 2) ? $clog2(DIV) : 1;

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tick = (cnt_q == W'(DIV - 1));

    // Next count: wrap to zero on the terminal count
    always_comb begin
        cnt_d = tick ? '0 : cnt_q + W'(1);
    end

    // Count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/display_scan_mux.sv
// Four-digit multiplexed display scanner with shift-in digit buffer.
// Optional macro LEADING_BLANK_EN blanks positions not yet entered.
module display_scan_mux
    import display_pkg::*;
#(
    parameter int REFRESH_DIV = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       wr_en,
    input  logic [3:0] wr_hex,
    input  logic       clr,
    output logic [3:0] hex_out,
    output logic [3:0] an_n,
    output logic [2:0] ndig
);

    digit_t [NDIG-1:0] d_q, d_d;
    logic   [2:0]      ndig_q, ndig_d;
    sidx_t             sidx_q, sidx_d;
    digit_t            hex_q, hex_d;
    logic   [3:0]      an_q, an_d;
    logic              tick;
    logic              blank;

    tick_div #(
        .DIV (REFRESH_DIV)
    ) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick)
    );

    // Digit buffer and count: clear beats write, count saturates at NDIG
    always_comb begin
        d_d    = d_q;
        ndig_d = ndig_q;
        if (clr) begin
            d_d    = '0;
            ndig_d = '0;
        end else if (wr_en) begin
            d_d = {d_q[NDIG-2:0], digit_t'(wr_hex)};
            if (ndig_q != 3'(NDIG)) ndig_d = ndig_q + 3'd1;
        end
    end

    // Scan position advances once per divider tick
    always_comb begin
        sidx_d = tick ? sidx_q + sidx_t'(1) : sidx_q;
    end

`ifdef LEADING_BLANK_EN
    assign blank = (sidx_q != '0) && ({1'b0, sidx_q} >= ndig_q);
`else
    assign blank = 1'b0;
`endif

    // Output register inputs: selected nibble and its anode pattern
    always_comb begin
        hex_d = d_q[sidx_q];
        an_d  = blank ? AN_OFF : an_sel(sidx_q);
    end

    // State and registered pin drivers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q    <= '0;
            ndig_q <= '0;
            sidx_q <= '0;
            hex_q  <= '0;
            an_q   <= AN_OFF;
        end else begin
            d_q    <= d_d;
            ndig_q <= ndig_d;
            sidx_q <= sidx_d;
            hex_q  <= hex_d;
            an_q   <= an_d;
        end
    end

    assign hex_out = hex_q;
    assign an_n    = an_q;
    assign ndig    = ndig_q;

endmodule

// File: tb/tb_display_scan_mux.sv
// Scoreboard bench for display_scan_mux with a cycle-count reference model.
// Works with or without LEADING_BLANK_EN defined.
module tb_display_scan_mux;

    localparam int DIV = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [3:0] wr_hex = 4'h0;
    logic       clr = 1'b0;
    logic [3:0] hex_out;
    logic [3:0] an_n;
    logic [2:0] ndig;

    int n_chk = 0;
    int n_err = 0;

    display_scan_mux #(.REFRESH_DIV(DIV)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_hex  (wr_hex),
        .clr     (clr),
        .hex_out (hex_out),
        .an_n    (an_n),
        .ndig    (ndig)
    );

    always #5 clk = ~clk;

    // Reference model: digit list (index 0 = rightmost), count, edges since release
    logic [3:0] m_d [4];
    int         m_n;
    int         m_edges;

    typedef struct packed {
        logic [3:0] hex;
        logic [3:0] an;
        logic [2:0] nd;
    } exp_t;

    exp_t q [$];

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int cur_slot();
        return (m_edges / DIV) % 4;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_d[i] = 4'h0;
        m_n = 0;
        m_edges = 0;
        q.delete();
    endtask

    // Called at a negedge: drive inputs, predict the next posedge, advance model
    task automatic step(input logic we, input logic [3:0] h, input logic c);
        exp_t e;
        int   s;
        s = cur_slot();
        e.hex = m_d[s];
        e.an = 4'b1111;
        e.an[s] = 1'b0;
`ifdef LEADING_BLANK_EN
        if (s != 0 && s >= m_n) e.an = 4'b1111;
`endif
        if (c) begin
            for (int i = 0; i < 4; i++) m_d[i] = 4'h0;
            m_n = 0;
        end else if (we) begin
            for (int i = 3; i > 0; i--) m_d[i] = m_d[i-1];
            m_d[0] = h;
            if (m_n < 4) m_n++;
        end
        e.nd = 3'(m_n);
        m_edges++;
        q.push_back(e);
        wr_en = we;
        wr_hex = h;
        clr = c;
        @(negedge clk);
    endtask

    task automatic idle(input int cycles);
        for (int i = 0; i < cycles; i++) step(1'b0, 4'h0, 1'b0);
    endtask

    // Monitor: compare the pins against the oldest prediction after each edge
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("hex_out", int'(hex_out), int'(e.hex));
                chk("an_n", int'(an_n), int'(e.an));
                chk("ndig", int'(ndig), int'(e.nd));
            end
        end
    end

    task automatic check_reset_pins(input string tag);
        chk({tag, "_an"}, int'(an_n), 'hf);
        chk({tag, "_hex"}, int'(hex_out), 0);
        chk({tag, "_ndig"}, int'(ndig), 0);
    endtask

    initial begin
        model_reset();
        #12;
        check_reset_pins("rst");
        @(negedge clk);
        rst_n = 1'b1;

        // Idle scan after release: 1110,1101,1011,0111,1110 with zeros
        idle(20);

        // Writes 1,2,3,4 back to back, then a full scan
        step(1'b1, 4'h1, 1'b0);
        step(1'b1, 4'h2, 1'b0);
        step(1'b1, 4'h3, 1'b0);
        step(1'b1, 4'h4, 1'b0);
        idle(16);

        // Write at saturation shifts the buffer, count stays 4
        step(1'b1, 4'h5, 1'b0);
        idle(16);

        // Clear wins over a simultaneous write
        step(1'b1, 4'h9, 1'b1);
        idle(16);

        // Single write of A: blanking visible when enabled
        step(1'b1, 4'hA, 1'b0);
        idle(16);

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            logic we, c;
            we = ($urandom_range(0, 2) == 0);
            c = ($urandom_range(0, 15) == 0);
            step(we, 4'($urandom), c);
        end

        // Asynchronous reset in the middle of slot 2
        while (cur_slot() != 2) step(1'b0, 4'h0, 1'b0);
        step(1'b0, 4'h0, 1'b0);
        @(posedge clk);
        #2;
        chk("qdrain", q.size(), 0);
        rst_n = 1'b0;
        #1;
        check_reset_pins("async");
        model_reset();
        @(negedge clk);
        check_reset_pins("hold");
        rst_n = 1'b1;
        idle(20);
        step(1'b1, 4'h7, 1'b0);
        idle(20);

        @(posedge clk);
        #3;
        chk("final_qdrain", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
